// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and bridge state types.
// Used by both the slave-side and master-side bridges.
package ahb_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_t;

  localparam logic [2:0] HSIZE_BYTE  = 3'd0;
  localparam logic [2:0] HSIZE_HALF  = 3'd1;
  localparam logic [2:0] HSIZE_WORD  = 3'd2;
  localparam logic [2:0] HSIZE_DWORD = 3'd3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_ERR1,
    ST_ERR2
  } bridge_state_t;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  function automatic int size_bytes(input logic [2:0] hsize);
    return 1 << hsize;
  endfunction

endpackage

// File: rtl/ahb_strb_gen.sv
// Byte-lane strobe generator: marks the 2^hsize lanes starting at addr_lsb.
// Reads always produce an all-zero strobe.
module ahb_strb_gen
  import ahb_pkg::*;
#(
  parameter  int DATA_WIDTH = 32,
  localparam int LANES      = DATA_WIDTH / 8,
  localparam int LSB_W      = $clog2(LANES)
) (
  input  logic [2:0]       hsize,
  input  logic [LSB_W-1:0] addr_lsb,
  input  logic             write,
  output logic [LANES-1:0] strb
);

  always_comb begin
    strb = '0;
    for (int i = 0; i < LANES; i++) begin
      if (write && (i >= int'(addr_lsb)) && (i < int'(addr_lsb) + size_bytes(hsize))) begin
        strb[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ahb_slave_bridge.sv
// AHB-Lite slave front end: turns address/data-phase transfers into a single
// ready-handshaked request and maps its completion back onto HREADYOUT/HRESP.
module ahb_slave_bridge
  import ahb_pkg::*;
#(
  parameter int AHB_ADDR_WIDTH = 32,
  parameter int AHB_DATA_WIDTH = 32,
  parameter int TIMEOUT        = 16
) (
  input  logic                        hclk,
  input  logic                        hresetn,
  input  logic                        hsel,
  input  logic [AHB_ADDR_WIDTH-1:0]   haddr,
  input  logic [1:0]                  htrans,
  input  logic                        hwrite,
  input  logic [2:0]                  hsize,
  input  logic [3:0]                  hprot,
  input  logic [AHB_DATA_WIDTH-1:0]   hwdata,
  input  logic                        hready,
  output logic [AHB_DATA_WIDTH-1:0]   hrdata,
  output logic                        slave_ready,
  output logic                        slave_error,
  output logic                        sel,
  output logic [AHB_ADDR_WIDTH-1:0]   addr,
  output logic                        write,
  output logic [AHB_DATA_WIDTH-1:0]   wdata,
  output logic [AHB_DATA_WIDTH/8-1:0] strb,
  output logic [3:0]                  prot,
  input  logic                        ready,
  input  logic [AHB_DATA_WIDTH-1:0]   rdata,
  input  logic                        other_error
);

  localparam int         LANES    = AHB_DATA_WIDTH / 8;
  localparam int         LSB_W    = $clog2(LANES);
  localparam logic [2:0] MAX_SIZE = 3'(LSB_W);
  localparam int         CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  bridge_state_t    state, next_state;
  logic [CNT_W-1:0] wait_cnt;
  logic [2:0]       size_q;
  logic [LSB_W-1:0] align_mask;
  logic             accept, illegal, done_ok, timed_out, take;

  // A new address phase is only taken when the previous data phase is ending.
  always_comb begin
    accept     = hsel && hready && ((htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ));
    align_mask = LSB_W'((32'd1 << hsize) - 32'd1);
    illegal    = (hsize > MAX_SIZE) || ((haddr[LSB_W-1:0] & align_mask) != '0);
    done_ok    = (state == ST_ACCESS) && ready && !other_error;
    timed_out  = (TIMEOUT != 0) && (wait_cnt == CNT_W'(TIMEOUT - 1));
    take       = accept && ((state == ST_IDLE) || (state == ST_ERR2) || done_ok);
  end

  always_ff @(posedge hclk) begin
    if (!hresetn) begin
      state    <= ST_IDLE;
      wait_cnt <= '0;
      addr     <= '0;
      write    <= 1'b0;
      size_q   <= '0;
      prot     <= '0;
    end else begin
      state <= next_state;
      if ((state == ST_ACCESS) && (next_state == ST_ACCESS) && !ready) begin
        wait_cnt <= wait_cnt + 1'b1;
      end else begin
        wait_cnt <= '0;
      end
      if (take) begin
        addr   <= haddr;
        write  <= hwrite;
        size_q <= hsize;
        prot   <= hprot;
      end
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: begin
        if (take) next_state = illegal ? ST_ERR1 : ST_ACCESS;
      end
      ST_ACCESS: begin
        if (ready) begin
          if (other_error)  next_state = ST_ERR1;
          else if (take)    next_state = illegal ? ST_ERR1 : ST_ACCESS;
          else              next_state = ST_IDLE;
        end else if (timed_out) begin
          next_state = ST_ERR1;
        end
      end
      ST_ERR1: next_state = ST_ERR2;
      ST_ERR2: begin
        if (take) next_state = illegal ? ST_ERR1 : ST_ACCESS;
        else      next_state = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // ERR1/ERR2 form the standard two-cycle AHB error response.
  always_comb begin
    sel         = 1'b0;
    slave_ready = 1'b1;
    slave_error = HRESP_OKAY;
    hrdata      = '0;
    case (state)
      ST_ACCESS: begin
        sel         = 1'b1;
        slave_ready = ready && !other_error;
        if (ready && !write) hrdata = rdata;
      end
      ST_ERR1: begin
        slave_ready = 1'b0;
        slave_error = HRESP_ERROR;
      end
      ST_ERR2: slave_error = HRESP_ERROR;
      default: ;
    endcase
  end

  assign wdata = hwdata;

  ahb_strb_gen #(.DATA_WIDTH(AHB_DATA_WIDTH)) u_strb_gen (
    .hsize    (size_q),
    .addr_lsb (addr[LSB_W-1:0]),
    .write    (write),
    .strb     (strb)
  );

endmodule

// File: tb/tb_ahb_slave_bridge.sv
// Scoreboard bench for ahb_slave_bridge: stimulus queues expected responses,
// a negedge monitor pops and compares them as the DUT presents results.
module tb_ahb_slave_bridge;
  import ahb_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 4;

  localparam int K_OK    = 0;
  localparam int K_ERR   = 1;
  localparam int K_ABORT = 2;

  typedef struct {
    int          kind;
    logic [31:0] addr;
    logic        write;
    logic [3:0]  strb;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [3:0]  prot;
    int          sel_cycles;
  } exp_t;

  logic          hclk;
  logic          hresetn;
  logic          hsel;
  logic [AW-1:0] haddr;
  logic [1:0]    htrans;
  logic          hwrite;
  logic [2:0]    hsize;
  logic [3:0]    hprot;
  logic [DW-1:0] hwdata;
  logic          hready;
  logic [DW-1:0] hrdata;
  logic          slave_ready;
  logic          slave_error;
  logic          sel;
  logic [AW-1:0] addr;
  logic          write;
  logic [DW-1:0] wdata;
  logic [3:0]    strb;
  logic [3:0]    prot;
  logic          ready;
  logic [DW-1:0] rdata;
  logic          other_error;

  exp_t exp_q[$];
  int   n_checks    = 0;
  int   n_failures  = 0;
  int   sel_count   = 0;
  logic expect_err2 = 1'b0;
  logic rst_at_edge = 1'b0;

  assign hready = slave_ready;

  ahb_slave_bridge #(
    .AHB_ADDR_WIDTH (AW),
    .AHB_DATA_WIDTH (DW),
    .TIMEOUT        (TO)
  ) dut (
    .hclk        (hclk),
    .hresetn     (hresetn),
    .hsel        (hsel),
    .haddr       (haddr),
    .htrans      (htrans),
    .hwrite      (hwrite),
    .hsize       (hsize),
    .hprot       (hprot),
    .hwdata      (hwdata),
    .hready      (hready),
    .hrdata      (hrdata),
    .slave_ready (slave_ready),
    .slave_error (slave_error),
    .sel         (sel),
    .addr        (addr),
    .write       (write),
    .wdata       (wdata),
    .strb        (strb),
    .prot        (prot),
    .ready       (ready),
    .rdata       (rdata),
    .other_error (other_error)
  );

  initial begin
    hclk = 1'b0;
    forever #5 hclk = ~hclk;
  end

  always @(posedge hclk) rst_at_edge <= !hresetn;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog actual=still_running expected=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_failures++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Monitor: every negedge, compare whatever the DUT is presenting against the queue head.
  always @(negedge hclk) begin
    exp_t h;
    if (rst_at_edge) begin
      if (exp_q.size() > 0 && exp_q[0].kind == K_ABORT) begin
        h = exp_q.pop_front();
        checkOutput("reset_sel", 64'(sel), 64'd0);
        checkOutput("reset_slave_ready", 64'(slave_ready), 64'd1);
        checkOutput("reset_slave_error", 64'(slave_error), 64'd0);
        checkOutput("reset_hrdata", 64'(hrdata), 64'd0);
        checkOutput("reset_addr", 64'(addr), 64'd0);
        checkOutput("reset_strb", 64'(strb), 64'd0);
        checkOutput("reset_prot", 64'(prot), 64'd0);
        checkOutput("abort_sel_cycles", 64'(sel_count), 64'(h.sel_cycles));
      end
      sel_count   = 0;
      expect_err2 = 1'b0;
    end else begin
      if (expect_err2) begin
        checkOutput("err2_resp", 64'({slave_ready, slave_error}), 64'(2'b11));
        expect_err2 = 1'b0;
      end
      if (sel === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_failures++;
          $display("[TB] FAIL unexpected_sel actual=1 expected=0 addr=0x%0h at %0t", addr, $time);
        end else begin
          h = exp_q[0];
          sel_count++;
          checkOutput("req_addr", 64'(addr), 64'(h.addr));
          checkOutput("req_write", 64'(write), 64'(h.write));
          checkOutput("req_strb", 64'(strb), 64'(h.strb));
          checkOutput("req_prot", 64'(prot), 64'(h.prot));
          if (ready && !other_error) begin
            checkOutput("resp_kind", 64'(h.kind), 64'(K_OK));
            checkOutput("ok_resp", 64'({slave_ready, slave_error}), 64'(2'b10));
            checkOutput("hrdata", 64'(hrdata), 64'(h.write ? 32'd0 : h.rdata));
            if (h.write) checkOutput("wdata", 64'(wdata), 64'(h.wdata));
            checkOutput("sel_cycles", 64'(sel_count), 64'(h.sel_cycles));
            void'(exp_q.pop_front());
            sel_count = 0;
          end else begin
            checkOutput("wait_slave_ready", 64'(slave_ready), 64'd0);
          end
        end
      end else if (slave_ready === 1'b0 && slave_error === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_failures++;
          $display("[TB] FAIL unexpected_error actual=error expected=none at %0t", $time);
        end else begin
          h = exp_q.pop_front();
          checkOutput("resp_kind", 64'(h.kind), 64'(K_ERR));
          checkOutput("err_sel_cycles", 64'(sel_count), 64'(h.sel_cycles));
          expect_err2 = 1'b1;
        end
        sel_count = 0;
      end
    end
  end

  // Single transfer: address phase, then data phase until HREADYOUT returns high.
  task automatic applyStimulus(input int kind, input logic [31:0] a, input logic w, input logic [2:0] s,
                               input logic [3:0] p, input logic [31:0] wd, input logic [31:0] rd,
                               input int waits, input logic err_inj, input logic [3:0] exp_strb,
                               input int exp_sel);
    exp_t e;
    int   cyc;
    logic done;
    e.kind = kind; e.addr = a; e.write = w; e.strb = exp_strb;
    e.wdata = wd; e.rdata = rd; e.prot = p; e.sel_cycles = exp_sel;
    exp_q.push_back(e);
    hsel = 1'b1; htrans = HTRANS_NONSEQ; haddr = a; hwrite = w; hsize = s; hprot = p;
    @(posedge hclk); #1;
    hsel = 1'b0; htrans = HTRANS_IDLE; hwdata = wd; rdata = rd;
    cyc = 0;
    done = 1'b0;
    while (!done && cyc < 20) begin
      ready       = (cyc >= waits);
      other_error = err_inj && (cyc >= waits);
      @(negedge hclk);
      done = slave_ready;
      @(posedge hclk); #1;
      cyc++;
    end
    if (!done) begin
      n_checks++;
      n_failures++;
      $display("[TB] FAIL transfer_timeout addr=0x%0h actual=no_hready expected=hready", a);
    end
    ready = 1'b0; other_error = 1'b0; hwdata = '0;
  endtask

  task automatic applyBackToBack(input logic [31:0] a1, input logic [31:0] d1,
                                 input logic [31:0] a2, input logic [31:0] d2);
    exp_t e;
    e.kind = K_OK; e.write = 1'b1; e.strb = 4'b1111; e.rdata = '0; e.prot = 4'h1; e.sel_cycles = 1;
    e.addr = a1; e.wdata = d1; exp_q.push_back(e);
    e.addr = a2; e.wdata = d2; exp_q.push_back(e);
    hsel = 1'b1; htrans = HTRANS_NONSEQ; haddr = a1; hwrite = 1'b1; hsize = 3'd2; hprot = 4'h1;
    @(posedge hclk); #1;
    haddr = a2; hwdata = d1; ready = 1'b1;
    @(posedge hclk); #1;
    hsel = 1'b0; htrans = HTRANS_IDLE; hwdata = d2;
    @(posedge hclk); #1;
    ready = 1'b0; hwdata = '0;
  endtask

  task automatic applyResetMidAccess(input logic [31:0] a);
    exp_t e;
    e.kind = K_ABORT; e.addr = a; e.write = 1'b0; e.strb = 4'b0000; e.wdata = '0;
    e.rdata = '0; e.prot = 4'hF; e.sel_cycles = 2;
    exp_q.push_back(e);
    hsel = 1'b1; htrans = HTRANS_NONSEQ; haddr = a; hwrite = 1'b0; hsize = 3'd2; hprot = 4'hF;
    @(posedge hclk); #1;
    hsel = 1'b0; htrans = HTRANS_IDLE; ready = 1'b0;
    @(posedge hclk); #1;
    hresetn = 1'b0;
    @(posedge hclk); #1;
    @(posedge hclk); #1;
    hresetn = 1'b1;
    @(posedge hclk); #1;
  endtask

  initial begin
    exp_t e;
    hresetn = 1'b0; hsel = 1'b0; haddr = '0; htrans = HTRANS_IDLE; hwrite = 1'b0;
    hsize = 3'd0; hprot = 4'h0; hwdata = '0; ready = 1'b0; rdata = '0; other_error = 1'b0;
    e.kind = K_ABORT; e.addr = '0; e.write = 1'b0; e.strb = '0; e.wdata = '0;
    e.rdata = '0; e.prot = '0; e.sel_cycles = 0;
    exp_q.push_back(e);
    repeat (3) @(posedge hclk);
    #1 hresetn = 1'b1;
    @(posedge hclk); #1;

    //            kind   addr          w     size  prot  wdata         rdata         wt  err   strb     sel
    applyStimulus(K_OK,  32'h0000_0100, 1'b1, 3'd2, 4'h3, 32'hDEADBEEF, 32'h0,        0,  1'b0, 4'b1111, 1);
    applyStimulus(K_OK,  32'h0000_0204, 1'b0, 3'd2, 4'h2, 32'h0,        32'h12345678, 3,  1'b0, 4'b0000, 4);
    applyStimulus(K_OK,  32'h0000_0003, 1'b1, 3'd0, 4'h0, 32'hAB000000, 32'h0,        0,  1'b0, 4'b1000, 1);
    applyStimulus(K_OK,  32'h0000_0002, 1'b1, 3'd1, 4'h0, 32'h55AA0000, 32'h0,        0,  1'b0, 4'b1100, 1);
    applyStimulus(K_ERR, 32'h0000_0002, 1'b1, 3'd2, 4'h0, 32'h11111111, 32'h0,        0,  1'b0, 4'b0000, 0);
    applyStimulus(K_OK,  32'h0000_0008, 1'b0, 3'd2, 4'h0, 32'h0,        32'hA5A50F0F, 1,  1'b0, 4'b0000, 2);
    applyStimulus(K_ERR, 32'h0000_0020, 1'b1, 3'd2, 4'h0, 32'h22222222, 32'h0,        0,  1'b1, 4'b1111, 1);
    applyStimulus(K_ERR, 32'h0000_0030, 1'b0, 3'd2, 4'h0, 32'h0,        32'h0,        100, 1'b0, 4'b0000, 4);
    applyStimulus(K_ERR, 32'h0000_0000, 1'b0, 3'd3, 4'h0, 32'h0,        32'h0,        0,  1'b0, 4'b0000, 0);
    applyStimulus(K_ERR, 32'h0000_0001, 1'b1, 3'd1, 4'h0, 32'h0,        32'h0,        0,  1'b0, 4'b0000, 0);
    applyBackToBack(32'h0000_0010, 32'h11111111, 32'h0000_0014, 32'h22222222);
    applyStimulus(K_OK,  32'h0000_0001, 1'b1, 3'd0, 4'h0, 32'h0000CD00, 32'h0,        0,  1'b0, 4'b0010, 1);
    applyStimulus(K_OK,  32'h0000_0006, 1'b0, 3'd1, 4'h0, 32'h0,        32'hBEEF0000, 0,  1'b0, 4'b0000, 1);
    applyResetMidAccess(32'h0000_0040);
    applyStimulus(K_OK,  32'h0000_0044, 1'b1, 3'd2, 4'h7, 32'h0BADF00D, 32'h0,        2,  1'b0, 4'b1111, 3);

    repeat (3) @(posedge hclk);
    #1;
    checkOutput("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_failures);
    $finish;
  end

endmodule
